// File: rtl/serial_pattern_detector.sv
// Serial detector for a run-time programmable N-bit pattern with overlap control,
// sample-enable qualification and a saturating hit counter.
module serial_pattern_detector #(
  parameter int N      = 3,
  parameter int CNT_W  = 8,
  parameter int FILL_W = $clog2(N + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             in,
  input  logic [N-1:0]     pattern,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             out,
  output logic             armed,
  output logic [CNT_W-1:0] hit_count
);

  typedef enum logic {FILL, ARMED} state_t;

  localparam logic [FILL_W-1:0] FULL = FILL_W'(N);

  logic [N-1:0]      sr_q, sr_d, win;
  logic [FILL_W-1:0] fill_q, fill_d, fill_sat;
  state_t            state_q, state_d;
  logic              out_q, out_d, hit;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    win      = {sr_q[N-2:0], in};
    fill_sat = (fill_q == FULL) ? FULL : fill_q + 1'b1;
    // A match is only eligible once N real samples are in the window.
    hit      = en && (fill_sat == FULL) && (win == pattern);
    sr_d     = en ? win : sr_q;
    fill_d   = fill_q;
    if (en) begin
      fill_d = (hit && !overlap) ? '0 : fill_sat;
    end
    state_d  = (fill_d == FULL) ? ARMED : FILL;
    out_d    = hit;
    cnt_d    = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q    <= '0;
      fill_q  <= '0;
      state_q <= FILL;
      out_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sr_q    <= sr_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out       = out_q;
  assign armed     = (state_q == ARMED);
  assign hit_count = cnt_q;

endmodule
